// File: rtl/rr_pri_sched.sv
// rtl/rr_pri_sched.sv - round-robin scheduler with MSB-first selection over a rotating mask
module rr_pri_sched #(
    parameter int WIDTH     = 56,
    parameter int WIDTH_LOG = 6,
    parameter int MAX_HOLD  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req,
    input  logic                 done,
    output logic                 gnt_valid,
    output logic [WIDTH_LOG-1:0] gnt_idx,
    output logic [WIDTH-1:0]     gnt_onehot,
    output logic                 timeout
);

    // Hold counter only needs to reach MAX_HOLD-1.
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    // Elaboration-time parameter sanity checks.
    generate
        if ((2 ** WIDTH_LOG) < WIDTH) begin : g_bad_width_log
            $error("rr_pri_sched: WIDTH_LOG too small for WIDTH");
        end
        if (MAX_HOLD < 2) begin : g_bad_max_hold
            $error("rr_pri_sched: MAX_HOLD must be at least 2");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               state_q,      state_d;
    logic [WIDTH_LOG-1:0] ptr_q,        ptr_d;
    logic [HOLD_W-1:0]    hold_cnt_q,   hold_cnt_d;
    logic                 gnt_valid_q,  gnt_valid_d;
    logic [WIDTH_LOG-1:0] gnt_idx_q,    gnt_idx_d;
    logic [WIDTH-1:0]     gnt_onehot_q, gnt_onehot_d;
    logic                 timeout_q,    timeout_d;

    logic [WIDTH-1:0]     low_mask;
    logic [WIDTH-1:0]     masked;
    logic                 masked_any;
    logic                 req_any;
    logic [WIDTH_LOG-1:0] masked_top;
    logic [WIDTH_LOG-1:0] req_top;
    logic [WIDTH_LOG-1:0] sel_idx;
    logic [WIDTH-1:0]     sel_onehot;

    // Index of the highest set bit; returns 0 for an all-zero vector.
    function automatic logic [WIDTH_LOG-1:0] msb_index(input logic [WIDTH-1:0] vec);
        logic [WIDTH_LOG-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = WIDTH_LOG'(i);
            end
        end
        return idx;
    endfunction

    // Rotating selection: highest requester strictly below ptr, else wrap to highest overall.
    always_comb begin
        low_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            low_mask[i] = (WIDTH_LOG'(i) < ptr_q);
        end
        masked     = req & low_mask;
        masked_any = |masked;
        req_any    = |req;
        masked_top = msb_index(masked);
        req_top    = msb_index(req);
        sel_idx    = masked_any ? masked_top : req_top;
        sel_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sel_onehot[i] = (sel_idx == WIDTH_LOG'(i));
        end
    end

    // Next-state and registered-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_cnt_d   = hold_cnt_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        timeout_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt_valid_d  = 1'b0;
                gnt_onehot_d = '0;
                if (req_any) begin
                    state_d      = ST_GRANT;
                    ptr_d        = sel_idx;
                    gnt_idx_d    = sel_idx;
                    gnt_onehot_d = sel_onehot;
                    gnt_valid_d  = 1'b1;
                    hold_cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                // req is deliberately ignored while a grant is held.
                if (done) begin
                    state_d      = ST_IDLE;
                    gnt_valid_d  = 1'b0;
                    gnt_onehot_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = ST_IDLE;
                    gnt_valid_d  = 1'b0;
                    gnt_onehot_d = '0;
                    timeout_d    = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d      = ST_IDLE;
                gnt_valid_d  = 1'b0;
                gnt_onehot_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            hold_cnt_q   <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            timeout_q    <= timeout_d;
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_pri_sched.sv
// tb/tb_rr_pri_sched.sv - directed scoreboard bench for rr_pri_sched
module tb_rr_pri_sched;

    localparam int W  = 56;
    localparam int WL = 6;
    localparam int MH = 16;

    logic          clk;
    logic          rst;
    logic [W-1:0]  req;
    logic          done;
    logic          gnt_valid;
    logic [WL-1:0] gnt_idx;
    logic [W-1:0]  gnt_onehot;
    logic          timeout;

    typedef struct packed {
        logic          v;
        logic [WL-1:0] idx;
        logic [W-1:0]  oh;
        logic          to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rr_pri_sched #(.WIDTH(W), .WIDTH_LOG(WL), .MAX_HOLD(MH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] bit_of(input int n);
        logic [W-1:0] one;
        one = 1;
        return one << n;
    endfunction

    // Drive one cycle of inputs, push what the outputs must be after the edge,
    // then pop and compare once the edge has passed.
    task automatic step(input logic r, input logic [W-1:0] rq, input logic d,
                        input logic ev, input int ei, input logic et, input string tag);
        exp_t e;
        rst  = r;
        req  = rq;
        done = d;
        e.v   = ev;
        e.idx = WL'(ei);
        e.oh  = ev ? bit_of(ei) : '0;
        e.to  = et;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        assert (gnt_valid === e.v) else begin
            errors++;
            $error("FAIL %s gnt_valid observed=%0b expected=%0b", tag, gnt_valid, e.v);
        end
        checks++;
        assert (gnt_idx === e.idx) else begin
            errors++;
            $error("FAIL %s gnt_idx observed=%0d expected=%0d", tag, gnt_idx, e.idx);
        end
        checks++;
        assert (gnt_onehot === e.oh) else begin
            errors++;
            $error("FAIL %s gnt_onehot observed=%h expected=%h", tag, gnt_onehot, e.oh);
        end
        checks++;
        assert (timeout === e.to) else begin
            errors++;
            $error("FAIL %s timeout observed=%0b expected=%0b", tag, timeout, e.to);
        end
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] r_rot;
        logic [W-1:0] r_mid;
        int           seq[4];
        ones  = '1;
        r_rot = bit_of(5) | bit_of(40);
        r_mid = bit_of(30) | bit_of(10);
        seq[0] = 40; seq[1] = 5; seq[2] = 40; seq[3] = 5;
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        #2;

        // Reset held 2 cycles with all requests and done high.
        step(1'b1, ones, 1'b1, 1'b0, 0, 1'b0, "reset_c1");
        step(1'b1, ones, 1'b1, 1'b0, 0, 1'b0, "reset_c2");
        step(1'b0, '0,   1'b0, 1'b0, 0, 1'b0, "reset_after");

        // Rotation between requesters 40 and 5; done high in the 3rd grant cycle.
        for (int g = 0; g < 4; g++) begin
            step(1'b0, r_rot, 1'b0, 1'b1, seq[g], 1'b0, "rot_g1");
            step(1'b0, r_rot, 1'b0, 1'b1, seq[g], 1'b0, "rot_g2");
            step(1'b0, r_rot, 1'b0, 1'b1, seq[g], 1'b0, "rot_g3");
            step(1'b0, r_rot, 1'b1, 1'b0, seq[g], 1'b0, "rot_release");
        end

        // Single requester with done always high: grant toggles every cycle.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, bit_of(0), 1'b1, 1'b1, 0, 1'b0, "single_grant");
            step(1'b0, bit_of(0), 1'b1, 1'b0, 0, 1'b0, "single_idle");
        end

        // Timeout: grant held exactly MH cycles, one-cycle pulse, then re-grant.
        for (int k = 0; k < MH; k++) begin
            step(1'b0, bit_of(55), 1'b0, 1'b1, 55, 1'b0, "to_hold");
        end
        step(1'b0, bit_of(55), 1'b0, 1'b0, 55, 1'b1, "to_pulse");
        step(1'b0, bit_of(55), 1'b0, 1'b1, 55, 1'b0, "to_regrant");

        // Done in the final allowed cycle wins over the hold limit.
        for (int k = 1; k < MH; k++) begin
            step(1'b0, bit_of(55), 1'b0, 1'b1, 55, 1'b0, "lim_hold");
        end
        step(1'b0, bit_of(55), 1'b1, 1'b0, 55, 1'b0, "lim_done");
        step(1'b0, '0,         1'b0, 1'b0, 55, 1'b0, "lim_no_pulse");

        // Reset in the 4th grant cycle of 30; ptr returns to 0 so 30 wins over 10.
        step(1'b0, bit_of(30), 1'b0, 1'b1, 30, 1'b0, "mid_g1");
        step(1'b0, bit_of(30), 1'b0, 1'b1, 30, 1'b0, "mid_g2");
        step(1'b0, bit_of(30), 1'b0, 1'b1, 30, 1'b0, "mid_g3");
        step(1'b0, bit_of(30), 1'b0, 1'b1, 30, 1'b0, "mid_g4");
        step(1'b1, bit_of(30), 1'b0, 1'b0, 0,  1'b0, "mid_reset");
        step(1'b0, r_mid,      1'b0, 1'b1, 30, 1'b0, "mid_regrant");
        step(1'b0, r_mid,      1'b1, 1'b0, 30, 1'b0, "mid_release");
        step(1'b0, r_mid,      1'b0, 1'b1, 10, 1'b0, "mid_rotate");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
